gray_counter: RTL and testbench

- Parametrised up/down counter that keeps its state in Gray code.
- Produces a registered Gray output and a registered binary output that always agree.
- Main consumers: CDC pointer logic (async FIFOs, credit counters), which needs a glitch-free, single-bit-change value to synchronise, plus a local binary value for arithmetic.
- Generalises the combinational Gray-to-binary conversion into a stateful, loadable, bidirectional counter.

---
 rtl/gray_counter.sv | 101 ++++++++++
 tb/tb_gray_counter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// gray_counter
//
// Up/down counter whose state is held in Gray code alongside a binary copy.
// The Gray output is taken straight from a flop so it can be handed to a
// clock-domain synchroniser; the binary output gives local logic a value it
// can do arithmetic on. Both registers always describe the same count.
//
// Parameters:
//   WIDTH   counter width in bits, 2 or more
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset, clears all outputs
//   clr_i   synchronous clear to zero (highest priority)
//   load_i  synchronous load of d_i (beats counting)
//   d_i     binary load value
//   en_i    count enable
//   down_i  count direction, 0 = up, 1 = down
//   gray_o  registered count in Gray code
//   bin_o   registered count in binary
//   wrap_o  registered one-cycle pulse when the count wraps
//
// Build option:
//   GRAY_COUNTER_SATURATE_EN  when defined, counting past either end holds
//                             the value and wrap_o becomes a limit-hit pulse.

module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] gray_o,
    output logic [WIDTH-1:0] bin_o,
    output logic             wrap_o
);

    // A one-bit counter has no meaningful Gray sequence, so refuse to build.
    generate
        if (WIDTH < 2) begin : g_width_check
            $error("gray_counter: WIDTH must be 2 or more");
        end
    endgenerate

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             next_wrap;
    logic             at_limit;

    // Next-state selection with clr > load > count priority. The Gray value
    // is derived from the next binary value rather than decoded back from
    // gray_o, so the path is one adder followed by a single XOR level.
    always_comb begin
        next_bin  = bin_o;
        next_wrap = 1'b0;
        at_limit  = down_i ? (bin_o == ZERO) : (bin_o == MAXV);

        if (clr_i) begin
            next_bin = ZERO;
        end else if (load_i) begin
            next_bin = d_i;
        end else if (en_i) begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (at_limit) begin
                next_bin  = bin_o;
                next_wrap = 1'b1;
            end else begin
                next_bin = down_i ? (bin_o - ONE) : (bin_o + ONE);
            end
`else
            next_bin  = down_i ? (bin_o - ONE) : (bin_o + ONE);
            next_wrap = at_limit;
`endif
        end

        next_gray = next_bin ^ (next_bin >> 1);
    end

    // Outputs are the flops themselves, so gray_o never glitches on its way
    // to a synchroniser in another clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_o  <= ZERO;
            gray_o <= ZERO;
            wrap_o <= 1'b0;
        end else begin
            bin_o  <= next_bin;
            gray_o <= next_gray;
            wrap_o <= next_wrap;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter
//
// Directed bench for gray_counter at WIDTH=4. Every expected value below is
// written out by hand from the Gray sequence of a 4-bit counter.

module tb_gray_counter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             en;
    logic             down;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             wrap;

    int assertCount;
    int failCount;

    gray_counter #(.WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (clr),
        .load_i (load),
        .d_i    (d),
        .en_i   (en),
        .down_i (down),
        .gray_o (gray),
        .bin_o  (bin),
        .wrap_o (wrap)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, then let one rising edge take them and settle.
    task automatic applyStimulus(input logic c, input logic l, input logic [WIDTH-1:0] dv,
                                 input logic e, input logic dn);
        clr  = c;
        load = l;
        d    = dv;
        en   = e;
        down = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input int expBin, input int expGray,
                            input int expWrap);
        checkOutput({tag, ".bin"},  32'(bin),  32'(expBin));
        checkOutput({tag, ".gray"}, 32'(gray), 32'(expGray));
        checkOutput({tag, ".wrap"}, 32'(wrap), 32'(expWrap));
    endtask

    // Hand-written 4-bit Gray sequence for counts 0..15.
    int grayTable [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        logic [WIDTH-1:0] prevGray;
        assertCount = 0;
        failCount   = 0;
        rst  = 1'b1;
        clr  = 1'b0;
        load = 1'b0;
        d    = '0;
        en   = 1'b0;
        down = 1'b0;

        // Reset state.
        #12;
        checkAll("reset", 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkAll("idle_after_reset", 0, 0, 0);

        // Full upward sweep, one Gray bit per step, wrap on return to zero.
        prevGray = gray;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
`ifdef GRAY_COUNTER_SATURATE_EN
            if (i == 16) begin
                checkAll($sformatf("up_%0d", i), 15, 8, 1);
            end else begin
                checkAll($sformatf("up_%0d", i), i, grayTable[i], 0);
                checkOutput($sformatf("up_hamming_%0d", i), 32'($countones(gray ^ prevGray)), 32'd1);
            end
`else
            checkAll($sformatf("up_%0d", i), i % 16, grayTable[i % 16], (i == 16) ? 1 : 0);
            checkOutput($sformatf("up_hamming_%0d", i), 32'($countones(gray ^ prevGray)), 32'd1);
`endif
            prevGray = gray;
        end

        // Down from zero after reset.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
`ifdef GRAY_COUNTER_SATURATE_EN
        checkAll("down_from_zero", 0, 0, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkAll("down_again", 0, 0, 1);
`else
        checkAll("down_from_zero", 15, 8, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkAll("down_again", 14, 9, 0);
`endif

        // Load beats count; then count up once.
        applyStimulus(1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
        checkAll("load_10", 10, 15, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkAll("up_from_10", 11, 14, 0);

        // Immediate direction change.
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkAll("dir_change", 10, 15, 0);

        // Hold with nothing asserted.
        applyStimulus(1'b0, 1'b0, 4'd3, 1'b0, 1'b1);
        checkAll("hold", 10, 15, 0);

        // Clear beats load and count.
        applyStimulus(1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        checkAll("load_7", 7, 4, 0);
        applyStimulus(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        checkAll("clr_priority", 0, 0, 0);

        // Asynchronous reset in the middle of a count.
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkAll("before_async", 5, 7, 0);
        #2;
        rst = 1'b1;
        #1;
        checkAll("async_reset", 0, 0, 0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkAll("after_release", 1, 1, 0);

        // Top-end behaviour: saturate or wrap depending on the build.
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
        checkAll("load_15", 15, 8, 0);
`ifdef GRAY_COUNTER_SATURATE_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            checkAll($sformatf("sat_up_%0d", i), 15, 8, 1);
        end
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkAll("sat_down", 0, 0, 1);
`else
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkAll("wrap_up_0", 0, 0, 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkAll("wrap_up_1", 1, 1, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        checkAll("wrap_up_2", 2, 3, 0);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        checkAll("wrap_down", 15, 8, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
